// File: rtl/linebuf_ctrl.sv
// Line-buffer sequencer for the demosaic window: counts x/y from video sync,
// drives RAM write/read strobes and addresses, rotates the write bank per line.
module linebuf_ctrl #(
    parameter int AW      = 11,
    parameter int IN_PCNT = 2,
    parameter int NLINE   = 4,
    parameter int PRIME   = 2,
    localparam int PW     = $clog2(IN_PCNT),
    localparam int WAW    = AW - PW,
    localparam int RW     = $clog2(NLINE)
) (
    input  logic             i_pclk,
    input  logic             i_arstn,
    input  logic             i_vsync,
    input  logic             i_hsync,
    input  logic             i_de,
    input  logic             i_valid,
    output logic             o_wr_en,
    output logic [NLINE-1:0] o_wr_bank,
    output logic [WAW-1:0]   o_wr_addr,
    output logic             o_rd_en,
    output logic [WAW-1:0]   o_rd_addr,
    output logic [RW-1:0]    o_rot,
    output logic             o_out_valid,
    output logic [AW-1:0]    o_x,
    output logic [AW-1:0]    o_y,
    output logic [AW-1:0]    o_line_len,
    output logic             o_ovf,
    output logic             o_len_err,
    output logic [1:0]       o_state,
    output logic             o_dbg_hsync
);

    localparam int FW = $clog2(NLINE + 1);
    localparam logic [WAW-1:0] WMAX  = '1;
    localparam logic [AW-1:0]  XSTEP = AW'(IN_PCNT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t         state;
    logic           vsync_q;
    logic           de_q;
    logic [1:0]     hsync_pipe;
    logic [AW-1:0]  x;
    logic [AW-1:0]  y;
    logic [FW-1:0]  fill;
    logic [FW-1:0]  fill_nxt;
    logic           ovf_line;
    logic           top_written;
    logic           had_beat;
    logic           s1_valid;
    logic [AW-1:0]  s1_x;
    logic [AW-1:0]  s1_y;
    logic           vs_rise;
    logic           line_end;
    logic           beat;

    // i_valid is a pure beat qualifier: there is no ready, so every beat
    // accepted while i_de is high and the line has not overflowed is consumed.
    assign vs_rise  = i_vsync & ~vsync_q;
    assign line_end = ~i_de & de_q;
    assign beat     = i_de & i_valid & (state != ST_IDLE) & ~ovf_line;
    assign fill_nxt = (fill == FW'(NLINE)) ? fill : fill + FW'(1);

    assign o_rd_en     = o_wr_en;
    assign o_rd_addr   = o_wr_addr;
    assign o_state     = state;
    assign o_dbg_hsync = hsync_pipe[1];

    always_ff @(posedge i_pclk) begin
        if (!i_arstn) begin
            state       <= ST_IDLE;
            vsync_q     <= 1'b0;
            de_q        <= 1'b0;
            hsync_pipe  <= '0;
            x           <= '0;
            y           <= '0;
            fill        <= '0;
            ovf_line    <= 1'b0;
            top_written <= 1'b0;
            had_beat    <= 1'b0;
            s1_valid    <= 1'b0;
            s1_x        <= '0;
            s1_y        <= '0;
            o_wr_en     <= 1'b0;
            o_wr_bank   <= NLINE'(1);
            o_wr_addr   <= '0;
            o_rot       <= '0;
            o_out_valid <= 1'b0;
            o_x         <= '0;
            o_y         <= '0;
            o_line_len  <= '0;
            o_ovf       <= 1'b0;
            o_len_err   <= 1'b0;
        end else begin
            vsync_q     <= i_vsync;
            de_q        <= i_de;
            hsync_pipe  <= {hsync_pipe[0], i_hsync};
            o_wr_en     <= 1'b0;
            s1_valid    <= 1'b0;
            // Second stage lines up with RAM read data.
            o_out_valid <= s1_valid;
            o_x         <= s1_x;
            o_y         <= s1_y;

            // vsync rise wins over a coincident line end: that line is discarded.
            if (vs_rise) begin
                state       <= ST_PRIME;
                x           <= '0;
                y           <= '0;
                fill        <= '0;
                ovf_line    <= 1'b0;
                top_written <= 1'b0;
                had_beat    <= 1'b0;
                o_wr_bank   <= NLINE'(1);
                o_rot       <= '0;
                o_line_len  <= '0;
                o_ovf       <= 1'b0;
                o_len_err   <= 1'b0;
            end else if (beat) begin
                if (top_written) begin
                    ovf_line <= 1'b1;
                    o_ovf    <= 1'b1;
                end else begin
                    o_wr_en   <= 1'b1;
                    o_wr_addr <= x[AW-1:PW];
                    x         <= x + XSTEP;
                    had_beat  <= 1'b1;
                    if (x[AW-1:PW] == WMAX)
                        top_written <= 1'b1;
                    s1_valid  <= (state == ST_RUN);
                    s1_x      <= x;
                    s1_y      <= y - AW'(PRIME);
                end
            end else if (line_end) begin
                if (had_beat) begin
                    if (o_line_len != '0 && o_line_len != x)
                        o_len_err <= 1'b1;
                    o_line_len <= x;
                    o_wr_bank  <= {o_wr_bank[NLINE-2:0], o_wr_bank[NLINE-1]};
                    o_rot      <= o_rot + RW'(1);
                    fill       <= fill_nxt;
                    if (y != '1)
                        y <= y + AW'(1);
                    if (state == ST_PRIME && fill_nxt >= FW'(PRIME))
                        state <= ST_RUN;
                end
                x           <= '0;
                ovf_line    <= 1'b0;
                top_written <= 1'b0;
                had_beat    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_linebuf_ctrl.sv
// Directed bench for linebuf_ctrl: a default instance plus a narrow AW=4
// instance sharing stimulus so the overflow corner is reachable.
module tb_linebuf_ctrl;

    logic clk;
    logic rst_n;
    logic vsync;
    logic hsync;
    logic de;
    logic valid;

    int checks;
    int errors;
    logic [31:0] exp_q[$];

    // default instance
    logic        wr_en, rd_en, out_valid, ovf, len_err, dbg_hs;
    logic [3:0]  wr_bank;
    logic [9:0]  wr_addr, rd_addr;
    logic [1:0]  rot, state;
    logic [10:0] ox, oy, line_len;

    // narrow instance
    logic        s_wr_en, s_rd_en, s_out_valid, s_ovf, s_len_err, s_dbg_hs;
    logic [3:0]  s_wr_bank;
    logic [2:0]  s_wr_addr, s_rd_addr;
    logic [1:0]  s_rot, s_state;
    logic [3:0]  s_ox, s_oy, s_line_len;

    linebuf_ctrl dut (
        .i_pclk(clk), .i_arstn(rst_n), .i_vsync(vsync), .i_hsync(hsync),
        .i_de(de), .i_valid(valid),
        .o_wr_en(wr_en), .o_wr_bank(wr_bank), .o_wr_addr(wr_addr),
        .o_rd_en(rd_en), .o_rd_addr(rd_addr), .o_rot(rot),
        .o_out_valid(out_valid), .o_x(ox), .o_y(oy), .o_line_len(line_len),
        .o_ovf(ovf), .o_len_err(len_err), .o_state(state), .o_dbg_hsync(dbg_hs)
    );

    linebuf_ctrl #(.AW(4)) dut_s (
        .i_pclk(clk), .i_arstn(rst_n), .i_vsync(vsync), .i_hsync(hsync),
        .i_de(de), .i_valid(valid),
        .o_wr_en(s_wr_en), .o_wr_bank(s_wr_bank), .o_wr_addr(s_wr_addr),
        .o_rd_en(s_rd_en), .o_rd_addr(s_rd_addr), .o_rot(s_rot),
        .o_out_valid(s_out_valid), .o_x(s_ox), .o_y(s_oy), .o_line_len(s_line_len),
        .o_ovf(s_ovf), .o_len_err(s_len_err), .o_state(s_state), .o_dbg_hsync(s_dbg_hs)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int         nbeats;
        bit         run;
        int         oy;
        int         rot;
        logic [3:0] bank;
        int         len;
        bit         err;
        int         st;
    } line_vec_t;

    line_vec_t tbl[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit vs, input bit de_i, input bit va);
        vsync = vs;
        de    = de_i;
        valid = va;
        hsync = ~de_i;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state();
        check("rst_wr_en", wr_en, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_wr_bank", wr_bank, 4'b0001);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_rot", rot, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_x", ox, 0);
        check("rst_y", oy, 0);
        check("rst_line_len", line_len, 0);
        check("rst_ovf", ovf, 0);
        check("rst_len_err", len_err, 0);
        check("rst_state", state, 0);
        check("rst_s_wr_bank", s_wr_bank, 4'b0001);
    endtask

    task automatic vsync_pulse();
        drive(1, 0, 0);
        check("vs_state", state, 1);
        drive(0, 0, 0);
    endtask

    // One line of n beats with a gap cycle after each beat.
    task automatic send_line(input int n, input bit run, input int exp_oy);
        logic [31:0] e;
        for (int k = 0; k < n; k++) begin
            drive(0, 1, 1);
            check("wr_en", wr_en, 1);
            check("wr_addr", wr_addr, k);
            check("rd_addr", rd_addr, k);
            if (k < 8) begin
                check("s_wr_en", s_wr_en, 1);
                check("s_wr_addr", s_wr_addr, k);
            end else begin
                check("s_wr_en_drop", s_wr_en, 0);
            end
            if (run) exp_q.push_back(k * 2);
            drive(0, 1, 0);
            check("wr_en_gap", wr_en, 0);
            check("out_valid", out_valid, run);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out_x: got %0h expected none", ox);
                end else begin
                    e = exp_q.pop_front();
                    check("out_x", ox, e);
                end
                check("out_y", oy, exp_oy);
            end
        end
        if (n == 0) repeat (4) drive(0, 1, 0);
        drive(0, 0, 0);
        drive(0, 0, 0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        tbl[0] = '{8, 0, 0, 1, 4'b0010, 16, 0, 1};
        tbl[1] = '{8, 0, 0, 2, 4'b0100, 16, 0, 2};
        tbl[2] = '{8, 1, 0, 3, 4'b1000, 16, 0, 2};
        tbl[3] = '{8, 1, 1, 0, 4'b0001, 16, 0, 2};
        tbl[4] = '{8, 1, 2, 1, 4'b0010, 16, 0, 2};
        tbl[5] = '{0, 0, 0, 1, 4'b0010, 16, 0, 2};
        tbl[6] = '{6, 1, 3, 2, 4'b0100, 12, 1, 2};

        rst_n = 1'b0;
        vsync = 0; de = 0; valid = 0; hsync = 1;
        repeat (3) drive(0, 0, 0);
        rst_n = 1'b1;
        check_reset_state();

        // beats before any vsync are ignored
        for (int k = 0; k < 4; k++) begin
            drive(0, 1, 1);
            check("idle_wr_en", wr_en, 0);
        end
        drive(0, 0, 0);

        // priming, wrap, length check, empty line
        vsync_pulse();
        for (int i = 0; i < 7; i++) begin
            send_line(tbl[i].nbeats, tbl[i].run, tbl[i].oy);
            check("tbl_rot", rot, tbl[i].rot);
            check("tbl_bank", wr_bank, tbl[i].bank);
            check("tbl_line_len", line_len, tbl[i].len);
            check("tbl_len_err", len_err, tbl[i].err);
            check("tbl_state", state, tbl[i].st);
        end
        check("exp_q_empty", exp_q.size(), 0);

        // overflow on the AW=4 instance
        vsync_pulse();
        check("vs_len_err_clr", len_err, 0);
        send_line(10, 0, 0);
        check("s_ovf_set", s_ovf, 1);
        check("s_line_len_ovf", s_line_len, 0);
        check("s_rot_ovf", s_rot, 1);
        check("line_len_20", line_len, 20);
        check("ovf_default", ovf, 0);
        send_line(2, 0, 0);
        check("s_ovf_sticky", s_ovf, 1);
        check("s_line_len_4", s_line_len, 4);
        check("s_len_err", s_len_err, 0);
        check("len_err_4", len_err, 1);
        vsync_pulse();
        check("s_ovf_clr", s_ovf, 0);
        check("vs_len_err", len_err, 0);
        check("vs_line_len", line_len, 0);
        check("vs_rot", rot, 0);
        check("vs_bank", wr_bank, 4'b0001);

        // vsync rise coincident with line end
        send_line(4, 0, 0);
        check("pre_col_rot", rot, 1);
        check("pre_col_len", line_len, 8);
        for (int k = 0; k < 4; k++) begin
            drive(0, 1, 1);
            drive(0, 1, 0);
        end
        drive(1, 0, 0);
        check("col_rot", rot, 0);
        check("col_bank", wr_bank, 4'b0001);
        check("col_state", state, 1);
        check("col_line_len", line_len, 0);
        drive(0, 0, 0);
        send_line(8, 0, 0);
        send_line(8, 0, 0);
        check("col_run", state, 2);
        send_line(8, 1, 0);
        check("col_exp_q_empty", exp_q.size(), 0);

        // reset mid-line with writes active
        drive(0, 1, 1);
        drive(0, 1, 0);
        rst_n = 1'b0;
        drive(0, 1, 1);
        check_reset_state();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, 1);
            check("post_rst_wr_en", wr_en, 0);
            drive(0, 1, 0);
        end
        drive(0, 0, 0);
        check("post_rst_rot", rot, 0);
        vsync_pulse();
        send_line(2, 0, 0);
        check("post_rst_bank", wr_bank, 4'b0010);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
